// File: rtl/alu_pkg.sv
// Shared types and entry layout for the ALU program sequencer.
// Entries are packed {instruction, A, B} with the opcode in the MSBs.
package alu_pkg;

    localparam int W       = 4;
    localparam int OPW     = 4;
    localparam int ENTRY_W = OPW + 2 * W;

    localparam int B_LSB  = 0;
    localparam int B_MSB  = W - 1;
    localparam int A_LSB  = W;
    localparam int A_MSB  = 2 * W - 1;
    localparam int OP_LSB = 2 * W;
    localparam int OP_MSB = 2 * W + OPW - 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    function automatic logic [ENTRY_W-1:0] pack_entry(
        input logic [OPW-1:0] op,
        input logic [W-1:0]   a,
        input logic [W-1:0]   b
    );
        logic [ENTRY_W-1:0] e;
        e                = '0;
        e[OP_MSB:OP_LSB] = op;
        e[A_MSB:A_LSB]   = a;
        e[B_MSB:B_LSB]   = b;
        return e;
    endfunction

endpackage

// File: rtl/alu_sequencer_delay.sv
// Shift register of {valid, addr} tags that tracks entries in flight
// through the ALU so each result can be matched to its address.
module seq_delay_line #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_data = r_stage[DEPTH-1];

endmodule

// File: rtl/alu_sequencer.sv
// Streams a loadable {instruction, A, B} program into the ALU one entry
// per cycle and reports each ALU result tagged with its program address.
module alu_sequencer #(
    parameter int W       = alu_pkg::W,
    parameter int OPW     = alu_pkg::OPW,
    parameter int DEPTH   = 16,
    parameter int ALU_LAT = 1,
    localparam int AW     = $clog2(DEPTH),
    localparam int EW     = OPW + 2 * W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load_en,
    input  logic [AW-1:0]  load_addr,
    input  logic [EW-1:0]  load_data,
    input  logic           start,
    input  logic [AW-1:0]  last_addr,
    output logic [W-1:0]   A,
    output logic [W-1:0]   B,
    output logic [OPW-1:0] instruction,
    input  logic [W-1:0]   alu_out,
    output logic           res_valid,
    output logic [W-1:0]   res_data,
    output logic [AW-1:0]  res_addr,
    output logic           busy,
    output logic           done
);

    import alu_pkg::*;

    state_e r_state;
    state_e w_next;

    logic [AW-1:0]  r_pc;
    logic [AW-1:0]  r_last;
    logic [EW-1:0]  r_mem [DEPTH];
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [OPW-1:0] r_instr;
    logic           r_res_valid;
    logic [W-1:0]   r_res_data;
    logic [AW-1:0]  r_res_addr;
    logic           r_done;

    logic           w_idle;
    logic           w_run;
    logic           w_drain;
    logic           w_pc_last;
    logic           w_tag_valid;
    logic [AW-1:0]  w_tag_addr;
    logic           w_last_res;
    logic [AW:0]    w_tag_in;
    logic [AW:0]    w_tag_out;

    assign w_idle    = (r_state == S_IDLE);
    assign w_run     = (r_state == S_RUN);
    assign w_drain   = (r_state == S_DRAIN);
    assign w_pc_last = (r_pc == r_last);

    // One tag per issued entry; bubbles while draining carry valid = 0.
    assign w_tag_in    = {w_run, (w_run ? r_pc : {AW{1'b0}})};
    assign w_tag_valid = w_tag_out[AW];
    assign w_tag_addr  = w_tag_out[AW-1:0];
    assign w_last_res  = w_tag_valid && (w_tag_addr == r_last);

    seq_delay_line #(
        .DEPTH (ALU_LAT + 1),
        .WIDTH (AW + 1)
    ) u_delay (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_data (w_tag_in),
        .o_data (w_tag_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_pc_last) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_last_res) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Program storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (w_idle && load_en) begin
            r_mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= '0;
            r_last  <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_instr <= '0;
        end else begin
            unique case (1'b1)
                w_idle: begin
                    r_a     <= '0;
                    r_b     <= '0;
                    r_instr <= '0;
                    if (start) begin
                        r_last <= last_addr;
                        r_pc   <= '0;
                    end
                end
                w_run: begin
                    {r_instr, r_a, r_b} <= r_mem[r_pc];
                    r_pc                <= r_pc + AW'(1);
                end
                w_drain: begin
                    r_a     <= '0;
                    r_b     <= '0;
                    r_instr <= '0;
                end
                default: begin
                    r_a     <= '0;
                    r_b     <= '0;
                    r_instr <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_addr  <= '0;
            r_done      <= 1'b0;
        end else begin
            r_res_valid <= w_tag_valid;
            r_done      <= w_last_res && w_drain;
            if (w_tag_valid) begin
                r_res_data <= alu_out;
                r_res_addr <= w_tag_addr;
            end
        end
    end

    assign A           = r_a;
    assign B           = r_b;
    assign instruction = r_instr;
    assign res_valid   = r_res_valid;
    assign res_data    = r_res_data;
    assign res_addr    = r_res_addr;
    assign done        = r_done;
    assign busy        = !w_idle;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer driving a behavioural 4-bit ALU
// with one cycle of latency.
module tb_alu_sequencer;

    import alu_pkg::*;

    localparam int AW = 4;

    localparam logic [3:0] RES_TBL [16] = '{
        4'h1, 4'hd, 4'h2, 4'hf, 4'hd, 4'h8, 4'he, 4'h3,
        4'h8, 4'h6, 4'hd, 4'h0, 4'ha, 4'h7, 4'h1, 4'h2
    };

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          load_en   = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [11:0]   load_data = '0;
    logic          start     = 1'b0;
    logic [AW-1:0] last_addr = '0;
    logic [3:0]    A;
    logic [3:0]    B;
    logic [3:0]    instruction;
    logic [3:0]    alu_out   = '0;
    logic          res_valid;
    logic [3:0]    res_data;
    logic [AW-1:0] res_addr;
    logic          busy;
    logic          done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [11:0] exp_ent [16];
    logic [3:0]  exp_res [16];

    alu_sequencer #(
        .W       (4),
        .OPW     (4),
        .DEPTH   (16),
        .ALU_LAT (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .start       (start),
        .last_addr   (last_addr),
        .A           (A),
        .B           (B),
        .instruction (instruction),
        .alu_out     (alu_out),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .res_addr    (res_addr),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] alu_f(
        input logic [3:0] op,
        input logic [3:0] a,
        input logic [3:0] b
    );
        logic [3:0] r;
        case (op)
            4'd0:    r = a + b;
            4'd1:    r = a - b;
            4'd2:    r = a & b;
            4'd3:    r = a | b;
            4'd4:    r = a ^ b;
            4'd5:    r = ~a;
            4'd6:    r = a << 1;
            4'd7:    r = a >> 1;
            4'd8:    r = a + 4'd1;
            4'd9:    r = a - 4'd1;
            4'd10:   r = ~(a & b);
            4'd11:   r = ~(a | b);
            4'd12:   r = b;
            4'd13:   r = a;
            4'd14:   r = {3'b000, (a < b)};
            default: r = a + b + 4'd1;
        endcase
        return r;
    endfunction

    always @(posedge clk) alu_out <= alu_f(instruction, A, B);

    task automatic chk(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_prog(input logic [AW-1:0] last, input bit inject);
        int n;
        int nres;
        int tdone;
        n     = int'(last);
        nres  = 0;
        tdone = -1;
        last_addr = last;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        load_en   = 1'b0;
        last_addr = '0;
        chk("busy_k", busy, 1);
        for (int t = 1; t <= n + 8; t++) begin
            if (inject && t == 2) begin
                load_en   = 1'b1;
                load_addr = 4'd2;
                load_data = pack_entry(4'hf, 4'hf, 4'hf);
                start     = 1'b1;
            end
            tick();
            if (inject && t == 2) begin
                load_en = 1'b0;
                start   = 1'b0;
            end
            if (t <= n + 1) begin
                chk("entry", {instruction, A, B}, exp_ent[t-1]);
            end
            chk("busy", busy, (t < n + 3));
            if (res_valid) begin
                chk("res_addr", res_addr, nres);
                chk("res_data", res_data, exp_res[nres % 16]);
                chk("res_time", t, nres + 3);
                chk("done_tag", done, (nres == n));
                if (done) tdone = t;
                nres++;
            end else if (done) begin
                chk("done_nv", done, 0);
            end
        end
        chk("n_res", nres, n + 1);
        chk("t_done", tdone, n + 3);
        chk("idle_ops", {instruction, A, B}, 0);
    endtask

    initial begin
        int bad;
        #12;
        chk("rst_ops", {instruction, A, B}, 0);
        chk("rst_res", {res_valid, res_data, res_addr}, 0);
        chk("rst_stat", {busy, done}, 0);
        rst_n = 1'b1;
        tick();

        // single-entry run
        load_en   = 1'b1;
        load_addr = 4'd0;
        load_data = pack_entry(4'h1, 4'h7, 4'ha);
        tick();
        load_en    = 1'b0;
        exp_ent[0] = pack_entry(4'h1, 4'h7, 4'ha);
        exp_res[0] = 4'hd;
        run_prog(4'd0, 1'b0);

        // full program, opcode = index
        for (int i = 0; i < 16; i++) begin
            load_en    = 1'b1;
            load_addr  = 4'(i);
            load_data  = pack_entry(4'(i), 4'h7, 4'ha);
            exp_ent[i] = pack_entry(4'(i), 4'h7, 4'ha);
            exp_res[i] = RES_TBL[i];
            tick();
        end
        load_en = 1'b0;
        run_prog(4'd15, 1'b0);

        // load and start in the same idle cycle
        load_en    = 1'b1;
        load_addr  = 4'd0;
        load_data  = pack_entry(4'h3, 4'h2, 4'h5);
        exp_ent[0] = pack_entry(4'h3, 4'h2, 4'h5);
        exp_res[0] = 4'h7;
        run_prog(4'd0, 1'b0);

        // load and start while busy are ignored
        run_prog(4'd15, 1'b1);
        run_prog(4'd15, 1'b0);

        // reset in the middle of a run
        last_addr = 4'd15;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        for (int t = 1; t <= 5; t++) tick();
        rst_n = 1'b0;
        #1;
        chk("mr_ops", {instruction, A, B}, 0);
        chk("mr_res", {res_valid, res_data, res_addr}, 0);
        chk("mr_stat", {busy, done}, 0);
        tick();
        rst_n = 1'b1;
        bad = 0;
        for (int t = 0; t < 25; t++) begin
            tick();
            if (res_valid || done || busy) bad++;
        end
        chk("mr_quiet", bad, 0);
        run_prog(4'd15, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
